// File: rtl/iter_shift_unit.sv
// iter_shift_unit
//   Multi-cycle shift/rotate execution unit. It accepts one decoded shift or
//   rotate request and moves the operand by one bit position per clock until
//   the requested amount is reached. A start/busy/done handshake lets the
//   execute stage stall while the unit works.
//
// Ports
//   clk     in   1      system clock, rising edge
//   rst_n   in   1      asynchronous reset, active-low
//   start   in   1      request, sampled only while idle
//   op      in   3      000 rotate, 001 SLL, 010 SRA, 011 SRL, 1xx illegal
//   flip    in   1      rotate direction for op=000 (0 left, 1 right)
//   shamt   in   SHW    shift amount 0..WIDTH-1
//   a_in    in   WIDTH  operand
//   busy    out  1      high from the cycle after acceptance through the done cycle
//   done    out  1      one-cycle completion pulse
//   err     out  1      high with done for an illegal op
//   result  out  WIDTH  registered result, held until the next accepted start
module iter_shift_unit #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             flip,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] a_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_ROT = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_SRL = 2'b11;

   state_t           state;
   state_t           state_next;
   logic [SHW-1:0]   count;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_step;
   logic [1:0]       op_q;
   logic             flip_q;
   logic [WIDTH-1:0] result_q;
   logic             err_q;
   logic             accept;
   logic             last_step;

   // One-bit move of the working register for the latched operation.
   function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] r,
                                               input logic [1:0]       o,
                                               input logic             f);
      logic [WIDTH-1:0] s;
      s = r;
      case (o)
         OP_ROT:  s = f ? {r[0], r[WIDTH-1:1]} : {r[WIDTH-2:0], r[WIDTH-1]};
         OP_SLL:  s = {r[WIDTH-2:0], 1'b0};
         OP_SRA:  s = {r[WIDTH-1], r[WIDTH-1:1]};
         OP_SRL:  s = {1'b0, r[WIDTH-1:1]};
         default: s = r;
      endcase
      return s;
   endfunction

   assign accept    = (state == IDLE) && start;
   assign last_step = (count == SHW'(1));
   assign work_step = step1(work, op_q, flip_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (op[2] || (shamt == '0)) state_next = DONE;
               else                        state_next = SHIFT;
            end
         end
         SHIFT:   if (last_step) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         work     <= '0;
         op_q     <= '0;
         flip_q   <= 1'b0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            op_q   <= op[1:0];
            flip_q <= flip;
            count  <= shamt;
            err_q  <= op[2];
            if (op[2]) begin
               // Illegal op reports a cleared result alongside err.
               work     <= '0;
               result_q <= '0;
            end else begin
               work <= a_in;
               if (shamt == '0) result_q <= a_in;
            end
         end else if (state == SHIFT) begin
            work <= work_step;
            // count is at least 1 in SHIFT, so it never wraps.
            if (count != '0) count <= count - SHW'(1);
            if (last_step) result_q <= work_step;
         end else if (state == DONE) begin
            err_q <= 1'b0;
         end
      end
   end

   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign err    = err_q && (state == DONE);
   assign result = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
module tb_iter_shift_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic        flip;
   logic [3:0]  shamt;
   logic [15:0] a_in;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;

   iter_shift_unit #(.WIDTH(16), .SHW(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .flip   (flip),
      .shamt  (shamt),
      .a_in   (a_in),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic        flip;
      logic [3:0]  shamt;
      logic [15:0] a;
      logic [15:0] exp_res;
      logic        exp_err;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: whole-amount shifts computed in one go with integer arithmetic.
   task automatic ref_model(input logic [2:0] o, input logic f, input logic [3:0] s,
                            input logic [15:0] a, output logic [15:0] r, output logic e);
      int unsigned ai;
      int unsigned n;
      logic signed [15:0] sa;
      ai = 32'(a);
      n  = 32'(s);
      e  = 1'b0;
      r  = '0;
      if (o[2]) begin
         e = 1'b1;
      end else begin
         case (o[1:0])
            2'b00: begin
               if (f) r = 16'((ai >> n) | (ai << (16 - n)));
               else   r = 16'((ai << n) | (ai >> (16 - n)));
            end
            2'b01: r = 16'(ai << n);
            2'b10: begin
               sa = a;
               sa = sa >>> n;
               r  = sa;
            end
            default: r = 16'(ai >> n);
         endcase
      end
   endtask

   function automatic int exp_latency(input logic [2:0] o, input logic [3:0] s);
      if (o[2] || s == 4'd0) return 1;
      return 1 + int'(s);
   endfunction

   // Issues one request from an IDLE negedge, returns result/err/latency,
   // then checks the following IDLE cycle. Leaves the bench at an IDLE negedge.
   task automatic run_op(input string tag, input logic [2:0] o, input logic f,
                         input logic [3:0] s, input logic [15:0] a,
                         input logic [15:0] exp_res, input logic exp_err);
      int lat;
      bit busy_ok;
      logic [15:0] res;
      logic e;
      op = o; flip = f; shamt = s; a_in = a; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Operands need not be held after acceptance.
      op = 3'($urandom); flip = 1'($urandom); shamt = 4'($urandom); a_in = 16'($urandom);
      lat = 0;
      busy_ok = 1'b1;
      forever begin
         @(negedge clk);
         lat++;
         if (!busy) busy_ok = 1'b0;
         if (done) break;
         if (err) busy_ok = 1'b0;
         if (lat > 40) break;
      end
      res = result;
      e   = err;
      check({tag, " latency"}, 32'(lat), 32'(exp_latency(o, s)));
      check({tag, " busy"}, 32'(busy_ok), 32'd1);
      check({tag, " result"}, 32'(res), 32'(exp_res));
      check({tag, " err"}, 32'(e), 32'(exp_err));
      @(negedge clk);
      check({tag, " idle after"}, {29'd0, busy, done, err}, 32'd0);
      check({tag, " result held"}, 32'(result), 32'(exp_res));
   endtask

   initial begin
      logic [15:0] r;
      logic e;
      logic [2:0] ro;
      logic rf;
      logic [3:0] rs;
      logic [15:0] ra;
      int lat;
      bit no_done;

      vecs[0]  = '{3'b000, 1'b0, 4'd1,  16'h8001, 16'h0003, 1'b0};
      vecs[1]  = '{3'b000, 1'b1, 4'd4,  16'h0001, 16'h1000, 1'b0};
      vecs[2]  = '{3'b010, 1'b0, 4'd15, 16'h8000, 16'hFFFF, 1'b0};
      vecs[3]  = '{3'b011, 1'b0, 4'd15, 16'h8000, 16'h0001, 1'b0};
      vecs[4]  = '{3'b001, 1'b0, 4'd8,  16'h00FF, 16'hFF00, 1'b0};
      vecs[5]  = '{3'b001, 1'b0, 4'd0,  16'h1234, 16'h1234, 1'b0};
      vecs[6]  = '{3'b101, 1'b0, 4'd3,  16'hABCD, 16'h0000, 1'b1};
      vecs[7]  = '{3'b000, 1'b0, 4'd0,  16'hBEEF, 16'hBEEF, 1'b0};
      vecs[8]  = '{3'b010, 1'b0, 4'd4,  16'h7F00, 16'h07F0, 1'b0};
      vecs[9]  = '{3'b000, 1'b1, 4'd15, 16'h8001, 16'h0003, 1'b0};
      vecs[10] = '{3'b111, 1'b1, 4'd0,  16'h5555, 16'h0000, 1'b1};
      vecs[11] = '{3'b000, 1'b0, 4'd15, 16'h0003, 16'h8001, 1'b0};

      rst_n = 1'b0; start = 1'b0; op = '0; flip = 1'b0; shamt = '0; a_in = '0;
      repeat (2) @(negedge clk);
      check("reset outputs", {12'd0, busy, done, err, 1'b0, result}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle after reset", {29'd0, busy, done, err}, 32'd0);

      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].flip, vecs[i].shamt,
                vecs[i].a, vecs[i].exp_res, vecs[i].exp_err);

      for (int i = 0; i < 40; i++) begin
         ro = ($urandom_range(0, 7) == 0) ? (3'b100 | 3'($urandom_range(0, 3)))
                                          : 3'($urandom_range(0, 3));
         rf = 1'($urandom);
         rs = 4'($urandom_range(0, 15));
         ra = 16'($urandom);
         ref_model(ro, rf, rs, ra, r, e);
         run_op($sformatf("rand%0d op%0d s%0d a%0h", i, ro, rs, ra), ro, rf, rs, ra, r, e);
      end

      // Starts while busy are ignored, including one during the DONE cycle.
      op = 3'b011; flip = 1'b0; shamt = 4'd10; a_in = 16'hF0F0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'b001; shamt = 4'd2; a_in = 16'hFFFF;
      lat = 0;
      forever begin
         @(negedge clk);
         lat++;
         if (done || lat > 40) break;
         start = (lat == 2 || lat == 5 || lat == 9);
      end
      check("busy-start latency", 32'(lat), 32'd11);
      check("busy-start result", 32'(result), 32'h003C);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start in done ignored", {30'd0, busy, done}, 32'd0);
      run_op("after ignore", 3'b000, 1'b0, 4'd2, 16'h4001, 16'h0005, 1'b0);

      // Asynchronous reset in the middle of a shift.
      op = 3'b011; flip = 1'b0; shamt = 4'd10; a_in = 16'hFFFF; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset mid-shift", {12'd0, busy, done, err, 1'b0, result}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      no_done = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done || busy) no_done = 1'b0;
      end
      check("no done after abort", 32'(no_done), 32'd1);
      run_op("after reset", 3'b010, 1'b0, 4'd3, 16'h9000, 16'hF200, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
